// File: rtl/mandelbrot_fb_writer.sv
// Mandelbrot framebuffer writer: maps iteration counts to colours through a
// writable palette RAM and writes them to the framebuffer over a req/ack bus.
// A small stats FSM counts acknowledged writes and raises done at frame end.
module mandelbrot_fb_writer #(
    parameter int              MAXITERS   = 256,
    parameter int              IW         = $clog2(MAXITERS),
    parameter int              AW         = 12,
    parameter int              MAW        = 24,
    parameter int              PW         = 16,
    parameter logic [PW-1:0]   INSIDE_COL = '0
) (
    input  logic           clk,
    input  logic           clk_en,
    input  logic           rst,
    input  logic           init,
    input  logic [31:0]    npixels,
    input  logic [MAW-1:0] fb_base,
    output logic           done,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic [IW-1:0]  in_dat,
    input  logic [AW-1:0]  in_adr,
    input  logic           pal_we,
    input  logic [IW-1:0]  pal_adr,
    input  logic [PW-1:0]  pal_dat,
    output logic           mem_cs,
    output logic           mem_we,
    output logic [MAW-1:0] mem_adr,
    output logic [PW-1:0]  mem_dat_w,
    input  logic           mem_ack
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Framebuffer address: base plus zero-extended pixel address, wrapping at 2^MAW.
    function automatic logic [MAW-1:0] fb_addr(input logic [MAW-1:0] base,
                                               input logic [AW-1:0]  pix);
        return base + MAW'(pix);
    endfunction

    // Pixels that never escaped get the fixed inside colour, not the palette entry.
    function automatic logic [PW-1:0] colour_sel(input logic [IW-1:0] iter,
                                                 input logic [PW-1:0] pal);
        return (iter == IW'(MAXITERS - 1)) ? INSIDE_COL : pal;
    endfunction

    logic [PW-1:0]  pal_mem [MAXITERS];

    logic           vld_p1;
    logic [IW-1:0]  iter_p1;
    logic [AW-1:0]  adr_p1;
    logic [PW-1:0]  pal_q_p1;

    logic           vld_p2;
    logic [MAW-1:0] mem_adr_p2;
    logic [PW-1:0]  mem_dat_p2;

    logic           p2_adv;
    logic           p1_adv;
    logic           in_xfer;
    logic           wr_ack;

    logic           init_r;
    logic           init_rise;
    state_t         state, state_nxt;
    logic [31:0]    cnt, cnt_nxt;

    assign p2_adv    = !vld_p2 || mem_ack;
    assign p1_adv    = vld_p1 && p2_adv;
    assign in_rdy    = !vld_p1 || p2_adv;
    assign in_xfer   = in_vld && in_rdy;
    assign wr_ack    = vld_p2 && mem_ack;
    assign init_rise = init && !init_r;

    assign mem_cs    = vld_p2;
    assign mem_we    = vld_p2;
    assign mem_adr   = mem_adr_p2;
    assign mem_dat_w = mem_dat_p2;
    assign done      = (state == S_DONE);

    // Palette RAM: single write port, read-first registered read on input transfer.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (pal_we)
                pal_mem[pal_adr] <= pal_dat;
            if (in_xfer)
                pal_q_p1 <= pal_mem[in_dat];
        end
    end

    // ---- stage P1: capture count/address alongside the palette read ----
    always_ff @(posedge clk) begin
        if (clk_en && in_xfer) begin
            iter_p1 <= in_dat;
            adr_p1  <= in_adr;
        end
    end

    // P1 valid: set on transfer, cleared when its pixel moves to P2.
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (clk_en) begin
            if (in_xfer)
                vld_p1 <= 1'b1;
            else if (p1_adv)
                vld_p1 <= 1'b0;
        end
    end

    // ---- stage P2: memory request register, held stable until acknowledged ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2     <= 1'b0;
            mem_adr_p2 <= '0;
            mem_dat_p2 <= '0;
        end else if (clk_en && p2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                mem_adr_p2 <= fb_addr(fb_base, adr_p1);
                mem_dat_p2 <= colour_sel(iter_p1, pal_q_p1);
            end
        end
    end

    // Stats FSM state, pixel counter and init edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            init_r <= 1'b0;
        end else if (clk_en) begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            init_r <= init;
        end
    end

    // Stats next state: init edge reloads and wins over a coincident ack.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (init_rise) begin
            cnt_nxt   = npixels;
            state_nxt = (npixels == 32'd0) ? S_DONE : S_RUN;
        end else if (state == S_RUN) begin
            if (cnt == 32'd0)
                state_nxt = S_DONE;
            else if (wr_ack) begin
                cnt_nxt = cnt - 32'd1;
                if (cnt == 32'd1)
                    state_nxt = S_DONE;
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_fb_writer.sv
// Directed bench for mandelbrot_fb_writer with an in-order write scoreboard.
module tb_mandelbrot_fb_writer;

    logic        clk = 1'b0;
    logic        clk_en, rst, init;
    logic [31:0] npixels;
    logic [23:0] fb_base;
    logic        done;
    logic        in_vld, in_rdy;
    logic [7:0]  in_dat;
    logic [11:0] in_adr;
    logic        pal_we;
    logic [7:0]  pal_adr;
    logic [15:0] pal_dat;
    logic        mem_cs, mem_we;
    logic [23:0] mem_adr;
    logic [15:0] mem_dat_w;
    logic        mem_ack;

    typedef struct packed {
        logic [23:0] adr;
        logic [15:0] col;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] pal_model [256];
    int          checks = 0;
    int          errors = 0;
    int          npushed = 0;
    int          nwritten = 0;

    always #5 clk = ~clk;

    mandelbrot_fb_writer dut (
        .clk       (clk),
        .clk_en    (clk_en),
        .rst       (rst),
        .init      (init),
        .npixels   (npixels),
        .fb_base   (fb_base),
        .done      (done),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_dat    (in_dat),
        .in_adr    (in_adr),
        .pal_we    (pal_we),
        .pal_adr   (pal_adr),
        .pal_dat   (pal_dat),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_dat_w (mem_dat_w),
        .mem_ack   (mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_col(input logic [7:0] dat);
        return (dat == 8'd255) ? 16'h0000 : pal_model[dat];
    endfunction

    task automatic push_exp(input logic [7:0] dat, input logic [11:0] adr);
        exp_t e;
        e.adr = fb_base + {12'h000, adr};
        e.col = exp_col(dat);
        exp_q.push_back(e);
        npushed++;
    endtask

    task automatic pal_write(input logic [7:0] idx, input logic [15:0] col);
        pal_we  = 1'b1;
        pal_adr = idx;
        pal_dat = col;
        tick();
        pal_we  = 1'b0;
        pal_model[idx] = col;
    endtask

    // Present one pixel, wait (bounded) for acceptance; returns in the cycle after the transfer.
    task automatic send(input logic [7:0] dat, input logic [11:0] adr);
        int n;
        in_vld = 1'b1;
        in_dat = dat;
        in_adr = adr;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_rdy && clk_en && !rst) break;
            n++;
            if (n > 200) begin
                check("send_timeout_in_rdy", in_rdy, 1'b1);
                break;
            end
        end
        push_exp(dat, adr);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++)
            @(negedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
        tick();
    endtask

    // Scoreboard: every acknowledged write must match the oldest pending pixel.
    always @(negedge clk) begin
        if (!rst && clk_en && mem_cs === 1'b1 && mem_ack) begin
            exp_t e;
            check("mem_we_eq_cs", mem_we, 1'b1);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed adr %0h with no pending pixel", mem_adr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_adr", mem_adr, e.adr);
                check("sb_dat", mem_dat_w, e.col);
            end
            nwritten++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before 300000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clk_en = 1'b1; init = 1'b0; npixels = '0; fb_base = '0;
        in_vld = 1'b0; in_dat = '0; in_adr = '0;
        pal_we = 1'b0; pal_adr = '0; pal_dat = '0; mem_ack = 1'b0;
        for (int i = 0; i < 256; i++) pal_model[i] = 16'h0000;

        // Reset state
        repeat (2) tick();
        check("rst_in_rdy", in_rdy, 1'b1);
        check("rst_mem_cs", mem_cs, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mem_adr", mem_adr, 24'h0);
        check("rst_mem_dat", mem_dat_w, 16'h0);
        rst = 1'b0;
        tick();

        // Palette setup
        pal_write(8'd5, 16'hABCD);
        pal_write(8'd7, 16'h0707);
        pal_write(8'd255, 16'h1234);
        for (int i = 0; i < 8; i++) pal_write(8'(10 + i), 16'hC000 + 16'(i));

        // Basic write and latency
        fb_base = 24'h100000;
        mem_ack = 1'b1;
        send(8'd5, 12'h010);
        in_vld = 1'b0;
        check("lat_c1_cs", mem_cs, 1'b0);
        tick();
        check("lat_c2_cs", mem_cs, 1'b1);
        check("lat_c2_adr", mem_adr, 24'h100010);
        check("lat_c2_dat", mem_dat_w, 16'hABCD);
        tick();
        check("lat_c3_cs_drop", mem_cs, 1'b0);

        // Inside colour overrides palette[255]
        send(8'd255, 12'h020);
        in_vld = 1'b0;
        tick();
        check("inside_dat", mem_dat_w, 16'h0000);
        tick();

        // Address wraps modulo 2^24
        fb_base = 24'hFFFFF0;
        send(8'd5, 12'h020);
        in_vld = 1'b0;
        tick();
        check("wrap_adr", mem_adr, 24'h000010);
        drain();
        fb_base = 24'h100000;

        // Back-pressure: two accepted, then stall for 10 cycles
        mem_ack = 1'b0;
        in_vld = 1'b1; in_dat = 8'd10; in_adr = 12'h100; push_exp(8'd10, 12'h100);
        tick();
        in_dat = 8'd11; in_adr = 12'h101; push_exp(8'd11, 12'h101);
        tick();
        in_dat = 8'd12; in_adr = 12'h102;
        for (int k = 0; k < 10; k++) begin
            check("bp_in_rdy_low", in_rdy, 1'b0);
            check("bp_cs_held", mem_cs, 1'b1);
            check("bp_adr_stable", mem_adr, 24'h100100);
            check("bp_dat_stable", mem_dat_w, 16'hC000);
            tick();
        end
        mem_ack = 1'b1;
        #1;
        check("bp_release_in_rdy", in_rdy, 1'b1);
        push_exp(8'd12, 12'h102);
        tick();
        for (int k = 1; k < 8; k++) begin
            if (k + 2 <= 7) begin
                in_dat = 8'(10 + k + 2);
                in_adr = 12'h100 + 12'(k + 2);
                check("bp_stream_in_rdy", in_rdy, 1'b1);
                push_exp(in_dat, in_adr);
            end else begin
                in_vld = 1'b0;
            end
            check("bp_stream_cs", mem_cs, 1'b1);
            check("bp_stream_adr", mem_adr, 24'h100100 + 24'(k));
            tick();
        end
        check("bp_stream_end_cs", mem_cs, 1'b0);
        drain();

        // Stats: npixels = 4
        init = 1'b1; npixels = 32'd4;
        tick();
        init = 1'b0;
        check("stats_after_init", done, 1'b0);
        for (int i = 0; i < 4; i++) send(8'd5, 12'h200 + 12'(i));
        in_vld = 1'b0;
        check("stats_pre_3", done, 1'b0);
        tick();
        check("stats_4th_ack_cycle", done, 1'b0);
        tick();
        check("stats_done", done, 1'b1);
        send(8'd5, 12'h210);
        in_vld = 1'b0;
        drain();
        check("stats_extra_ack_done", done, 1'b1);

        // Re-init clears done
        init = 1'b1; npixels = 32'd4;
        tick();
        init = 1'b0;
        check("reinit_done_low", done, 1'b0);
        tick();

        // npixels = 0
        npixels = 32'd0; init = 1'b1;
        tick();
        check("zero_pix_done", done, 1'b1);
        init = 1'b0;
        tick();
        check("zero_pix_done_hold", done, 1'b1);

        // Palette read/write collision returns the old colour
        pal_we = 1'b1; pal_adr = 8'd7; pal_dat = 16'hBEEF;
        send(8'd7, 12'h030);
        pal_we = 1'b0;
        pal_model[7] = 16'hBEEF;
        send(8'd7, 12'h031);
        in_vld = 1'b0;
        drain();

        // clk_en low mid-stream
        send(8'd10, 12'h300);
        send(8'd11, 12'h301);
        clk_en = 1'b0;
        in_vld = 1'b1; in_dat = 8'd12; in_adr = 12'h302;
        for (int k = 0; k < 3; k++) begin
            check("ce_cs_frozen", mem_cs, 1'b1);
            check("ce_adr_frozen", mem_adr, 24'h100300);
            check("ce_dat_frozen", mem_dat_w, 16'hC000);
            tick();
        end
        clk_en = 1'b1;
        send(8'd12, 12'h302);
        send(8'd13, 12'h303);
        in_vld = 1'b0;
        drain();
        check("total_writes", nwritten, npushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
